// File: rtl/branch_unit_arb_pkg.sv
// Shared types and constants for the branch-unit arbiter slice.
// The optional watchdog is enabled by defining BRANCH_ARB_TIMEOUT_EN.
package branch_unit_arb_pkg;

   localparam int BRARB_TIMEOUT_DEFAULT = 15;

   typedef enum logic [1:0] {
      BRARB_IDLE  = 2'd0,
      BRARB_BUSY  = 2'd1,
      BRARB_FLUSH = 2'd2
   } brarb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr,
// wrapping modulo N. Reusable by other issue arbiters.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   input  logic                 en,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] idx
);

   localparam int IDX_W = $clog2(N);

   logic [IDX_W-1:0] cand;
   logic             found;

   // Scan from the pointer upward; the first hit wins.
   always_comb begin
      gnt   = '0;
      idx   = '0;
      cand  = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         cand = IDX_W'((int'(ptr) + i) % N);
         if (en && !found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/branch_unit_arb.sv
// Round-robin arbiter sharing one branch unit among N_REQ requesters.
// Define BRANCH_ARB_TIMEOUT_EN to add the BUSY watchdog and timeout_o.
module branch_unit_arb
   import branch_unit_arb_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int TAG_W   = 5,
   parameter int TIMEOUT = BRARB_TIMEOUT_DEFAULT
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic [N_REQ-1:0]         req_valid_i,
   input  logic [N_REQ*TAG_W-1:0]   req_tag_i,
   output logic [N_REQ-1:0]         req_ready_o,
   input  logic                     flush_i,
   input  logic                     bu_ops_ready_i,
   output logic                     bu_ops_valid_o,
   output logic [N_REQ-1:0]         bu_sel_o,
   input  logic                     bu_res_valid_i,
   input  logic                     bu_res_taken_i,
   input  logic                     bu_res_mispredict_i,
   output logic                     res_valid_o,
   output logic [$clog2(N_REQ)-1:0] res_src_o,
   output logic [TAG_W-1:0]         res_tag_o,
   output logic                     res_taken_o,
   output logic                     res_mispredict_o,
`ifdef BRANCH_ARB_TIMEOUT_EN
   output logic                     timeout_o,
`endif
   output logic                     flush_o
);

   localparam int SRC_W = $clog2(N_REQ);

   brarb_state_t     state;
   logic [SRC_W-1:0] ptr;
   logic [SRC_W-1:0] fl_src;
   logic [TAG_W-1:0] fl_tag;
   logic [N_REQ-1:0] gnt;
   logic [SRC_W-1:0] gnt_idx;
   logic [TAG_W-1:0] gnt_tag;
   logic             arb_en;

`ifdef BRANCH_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] busy_cnt;
`endif

   // Grant path is combinational and held low while reset is asserted.
   assign arb_en         = rst_n_i && (state == BRARB_IDLE) && bu_ops_ready_i && !flush_i;
   assign bu_ops_valid_o = rst_n_i && (state == BRARB_IDLE) && (|req_valid_i);
   assign req_ready_o    = gnt;
   assign bu_sel_o       = gnt;
   assign gnt_tag        = req_tag_i[gnt_idx*TAG_W +: TAG_W];

   rr_arbiter #(.N(N_REQ)) u_rr (
      .req (req_valid_i),
      .ptr (ptr),
      .en  (arb_en),
      .gnt (gnt),
      .idx (gnt_idx)
   );

   // Control FSM; result, flush and timeout outputs are single-cycle pulses.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state            <= BRARB_IDLE;
         ptr              <= '0;
         fl_src           <= '0;
         fl_tag           <= '0;
         res_valid_o      <= 1'b0;
         res_src_o        <= '0;
         res_tag_o        <= '0;
         res_taken_o      <= 1'b0;
         res_mispredict_o <= 1'b0;
         flush_o          <= 1'b0;
`ifdef BRANCH_ARB_TIMEOUT_EN
         timeout_o        <= 1'b0;
         busy_cnt         <= '0;
`endif
      end else begin
         res_valid_o <= 1'b0;
         flush_o     <= 1'b0;
`ifdef BRANCH_ARB_TIMEOUT_EN
         timeout_o   <= 1'b0;
`endif
         case (state)
            BRARB_IDLE: begin
               if (|gnt) begin
                  fl_src <= gnt_idx;
                  fl_tag <= gnt_tag;
                  ptr    <= (gnt_idx == SRC_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                  state  <= BRARB_BUSY;
`ifdef BRANCH_ARB_TIMEOUT_EN
                  busy_cnt <= '0;
`endif
               end
            end
            BRARB_BUSY: begin
               if (flush_i) begin
                  state <= BRARB_IDLE;
               end else if (bu_res_valid_i) begin
                  res_valid_o      <= 1'b1;
                  res_src_o        <= fl_src;
                  res_tag_o        <= fl_tag;
                  res_taken_o      <= bu_res_taken_i;
                  res_mispredict_o <= bu_res_mispredict_i;
                  if (bu_res_mispredict_i) begin
                     flush_o <= 1'b1;
                     state   <= BRARB_FLUSH;
                  end else begin
                     state   <= BRARB_IDLE;
                  end
               end
`ifdef BRANCH_ARB_TIMEOUT_EN
               else if (busy_cnt == CNT_W'(TIMEOUT - 1)) begin
                  timeout_o <= 1'b1;
                  state     <= BRARB_IDLE;
               end else begin
                  busy_cnt <= busy_cnt + 1'b1;
               end
`endif
            end
            BRARB_FLUSH: state <= BRARB_IDLE;
            default:     state <= BRARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_branch_unit_arb.sv
// Scoreboard bench for branch_unit_arb: expected results are queued when the
// branch-unit response is driven and popped when res_valid_o appears.
module tb_branch_unit_arb;

   localparam int N_REQ = 4;
   localparam int TAG_W = 5;

   logic                   clk_i = 1'b0;
   logic                   rst_n_i;
   logic [N_REQ-1:0]       req_valid_i;
   logic [N_REQ*TAG_W-1:0] req_tag_i;
   logic [N_REQ-1:0]       req_ready_o;
   logic                   flush_i;
   logic                   bu_ops_ready_i;
   logic                   bu_ops_valid_o;
   logic [N_REQ-1:0]       bu_sel_o;
   logic                   bu_res_valid_i;
   logic                   bu_res_taken_i;
   logic                   bu_res_mispredict_i;
   logic                   res_valid_o;
   logic [1:0]             res_src_o;
   logic [TAG_W-1:0]       res_tag_o;
   logic                   res_taken_o;
   logic                   res_mispredict_o;
   logic                   flush_o;
`ifdef BRANCH_ARB_TIMEOUT_EN
   logic                   timeout_o;
`endif

   typedef struct {
      int   src;
      int   tag;
      logic taken;
      logic misp;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   ptr_model;
   int   g;

   always #5 clk_i = ~clk_i;

   branch_unit_arb #(.N_REQ(N_REQ), .TAG_W(TAG_W), .TIMEOUT(15)) dut (
      .clk_i               (clk_i),
      .rst_n_i             (rst_n_i),
      .req_valid_i         (req_valid_i),
      .req_tag_i           (req_tag_i),
      .req_ready_o         (req_ready_o),
      .flush_i             (flush_i),
      .bu_ops_ready_i      (bu_ops_ready_i),
      .bu_ops_valid_o      (bu_ops_valid_o),
      .bu_sel_o            (bu_sel_o),
      .bu_res_valid_i      (bu_res_valid_i),
      .bu_res_taken_i      (bu_res_taken_i),
      .bu_res_mispredict_i (bu_res_mispredict_i),
      .res_valid_o         (res_valid_o),
      .res_src_o           (res_src_o),
      .res_tag_o           (res_tag_o),
      .res_taken_o         (res_taken_o),
      .res_mispredict_o    (res_mispredict_o),
`ifdef BRANCH_ARB_TIMEOUT_EN
      .timeout_o           (timeout_o),
`endif
      .flush_o             (flush_o)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] v, input logic rdy, input logic fl,
                                input logic rv, input logic tk, input logic mp);
      @(negedge clk_i);
      req_valid_i         = v;
      bu_ops_ready_i      = rdy;
      flush_i             = fl;
      bu_res_valid_i      = rv;
      bu_res_taken_i      = tk;
      bu_res_mispredict_i = mp;
      #1;
   endtask

   function automatic int rrPick(input logic [3:0] v, input int p);
      for (int i = 0; i < N_REQ; i++)
         if (v[(p + i) % N_REQ]) return (p + i) % N_REQ;
      return -1;
   endfunction

   function automatic logic [3:0] oneHot(input int idx);
      logic [3:0] r;
      r = '0;
      if (idx >= 0) r[idx] = 1'b1;
      return r;
   endfunction

   function automatic int tagOf(input int idx);
      return 8 + idx;
   endfunction

   task automatic pushExp(input int src, input logic tk, input logic mp);
      exp_t e;
      e.src   = src;
      e.tag   = (src == 2) ? 17 : tagOf(src);
      e.taken = tk;
      e.misp  = mp;
      exp_q.push_back(e);
   endtask

   // Result monitor: every res_valid_o pulse must match the queue head.
   always @(negedge clk_i) begin
      if (res_valid_o) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_res", 32'(res_valid_o), 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput("res_src",  32'(res_src_o), 32'(e.src));
            checkOutput("res_tag",  32'(res_tag_o), 32'(e.tag));
            checkOutput("res_taken", 32'(res_taken_o), 32'(e.taken));
            checkOutput("res_misp", 32'(res_mispredict_o), 32'(e.misp));
         end
      end
   end

   initial begin
      logic [3:0] all_v;
      all_v = 4'b1111;
      for (int i = 0; i < N_REQ; i++)
         req_tag_i[i*TAG_W +: TAG_W] = (i == 2) ? 5'd17 : TAG_W'(tagOf(i));
      rst_n_i = 1'b0;
      applyStimulus(all_v, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      checkOutput("rst_ready",     32'(req_ready_o), 32'd0);
      checkOutput("rst_ops_valid", 32'(bu_ops_valid_o), 32'd0);
      checkOutput("rst_res_valid", 32'(res_valid_o), 32'd0);
      checkOutput("rst_flush",     32'(flush_o), 32'd0);
      applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n_i = 1'b1;
      #1;
      checkOutput("post_rst_ready", 32'(req_ready_o), 32'd0);
      checkOutput("post_rst_res",   32'(res_valid_o), 32'd0);
      ptr_model = 0;

      $display("[TB] round-robin with all requesters valid");
      for (int k = 0; k < 5; k++) begin
         applyStimulus(all_v, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         g = rrPick(all_v, ptr_model);
         checkOutput("rr_grant",     32'(req_ready_o), 32'(oneHot(g)));
         checkOutput("rr_sel",       32'(bu_sel_o), 32'(oneHot(g)));
         checkOutput("rr_ops_valid", 32'(bu_ops_valid_o), 32'd1);
         ptr_model = (g + 1) % N_REQ;
         applyStimulus(all_v, 1'b1, 1'b0, 1'b1, 1'(k), 1'b0);
         checkOutput("rr_busy_nogrant", 32'(req_ready_o), 32'd0);
         pushExp(g, 1'(k), 1'b0);
      end

      $display("[TB] mispredict on requester 2");
      applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      g = rrPick(4'b0100, ptr_model);
      checkOutput("mp_grant", 32'(req_ready_o), 32'(oneHot(g)));
      ptr_model = (g + 1) % N_REQ;
      applyStimulus(4'b0100, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      checkOutput("mp_busy_nogrant", 32'(req_ready_o), 32'd0);
      pushExp(g, 1'b1, 1'b1);
      applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("mp_flush_nogrant", 32'(req_ready_o), 32'd0);
      checkOutput("mp_flush_hi",      32'(flush_o), 32'd1);
      checkOutput("mp_res_valid",     32'(res_valid_o), 32'd1);
      applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("mp_flush_lo", 32'(flush_o), 32'd0);
      g = rrPick(4'b0100, ptr_model);
      checkOutput("mp_regrant", 32'(req_ready_o), 32'(oneHot(g)));
      ptr_model = (g + 1) % N_REQ;

      $display("[TB] external flush with coincident result");
      applyStimulus(4'b0010, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      checkOutput("fl_busy_nogrant", 32'(req_ready_o), 32'd0);
      applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("fl_no_res",   32'(res_valid_o), 32'd0);
      checkOutput("fl_no_flush", 32'(flush_o), 32'd0);
      g = rrPick(4'b0010, ptr_model);
      checkOutput("fl_regrant", 32'(req_ready_o), 32'(oneHot(g)));
      ptr_model = (g + 1) % N_REQ;
      applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      pushExp(g, 1'b0, 1'b0);

      $display("[TB] branch unit not ready");
      for (int k = 0; k < 5; k++) begin
         applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         checkOutput("nr_no_grant",  32'(req_ready_o), 32'd0);
         checkOutput("nr_ops_valid", 32'(bu_ops_valid_o), 32'd1);
      end
      applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      g = rrPick(4'b0010, ptr_model);
      checkOutput("nr_grant", 32'(req_ready_o), 32'(oneHot(g)));

      $display("[TB] reset while busy");
      @(negedge clk_i);
      rst_n_i             = 1'b0;
      req_valid_i         = all_v;
      bu_res_valid_i      = 1'b1;
      bu_res_taken_i      = 1'b1;
      bu_res_mispredict_i = 1'b1;
      #1;
      checkOutput("mid_rst_ready",     32'(req_ready_o), 32'd0);
      checkOutput("mid_rst_ops_valid", 32'(bu_ops_valid_o), 32'd0);
      checkOutput("mid_rst_sel",       32'(bu_sel_o), 32'd0);
      applyStimulus(all_v, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      checkOutput("mid_rst_res",   32'(res_valid_o), 32'd0);
      checkOutput("mid_rst_flush", 32'(flush_o), 32'd0);
      @(negedge clk_i);
      rst_n_i        = 1'b1;
      bu_res_valid_i = 1'b0;
      #1;
      ptr_model = 0;
      g = rrPick(all_v, ptr_model);
      checkOutput("post_rst_grant", 32'(req_ready_o), 32'(oneHot(g)));
      ptr_model = (g + 1) % N_REQ;
      applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      pushExp(g, 1'b1, 1'b0);

      $display("[TB] stray result while idle");
      applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("stray_no_res",   32'(res_valid_o), 32'd0);
      checkOutput("stray_no_flush", 32'(flush_o), 32'd0);

`ifdef BRANCH_ARB_TIMEOUT_EN
      $display("[TB] watchdog timeout");
      applyStimulus(4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      g = rrPick(4'b1000, ptr_model);
      checkOutput("to_grant", 32'(req_ready_o), 32'(oneHot(g)));
      ptr_model = (g + 1) % N_REQ;
      for (int k = 1; k <= 15; k++) begin
         applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         checkOutput("to_early", 32'(timeout_o), 32'd0);
      end
      applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("to_pulse", 32'(timeout_o), 32'd1);
      checkOutput("to_no_res", 32'(res_valid_o), 32'd0);
      g = rrPick(4'b0001, ptr_model);
      checkOutput("to_regrant", 32'(req_ready_o), 32'(oneHot(g)));
      applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("to_pulse_end", 32'(timeout_o), 32'd0);
      pushExp(g, 1'b0, 1'b0);
`endif

      applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_unit_arb.md
Name: branch_unit_arb

Overview:
- Shares the single branch unit between N_REQ requesters, such as branch reservation-station slots or ports.
- Grants one operation at a time using round-robin arbitration and drives a one-hot operand-mux select.
- Tracks the single in-flight operation and returns its result tagged with requester index and ROB tag.
- Raises a one-cycle flush request on mispredict.
- Sits between issue logic and the branch unit control/datapath.

Parameters:
- N_REQ, 4, number of requesters (≥2).
- TAG_W, 5, ROB tag width.
- TIMEOUT, 15, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- req_valid_i  in  N_REQ  per-requester operation valid
- req_tag_i  in  N_REQ×TAG_W  per-requester ROB tag
- req_ready_o  out  N_REQ  one-hot grant/accept
- flush_i  in  1  external pipeline flush; kills the in-flight op
- bu_ops_ready_i  in  1  branch unit can accept operands
- bu_ops_valid_o  out  1  operands valid to branch unit
- bu_sel_o  out  N_REQ  one-hot operand-mux select (equals req_ready_o)
- bu_res_valid_i  in  1  branch unit result valid
- bu_res_taken_i  in  1  resolved direction
- bu_res_mispredict_i  in  1  misprediction flag
- res_valid_o  out  1  tagged result valid
- res_src_o  out  $clog2(N_REQ)  index of the originating requester
- res_tag_o  out  TAG_W  ROB tag of the result
- res_taken_o  out  1  registered copy of taken
- res_mispredict_o  out  1  registered copy of mispredict
- flush_o  out  1  one-cycle mispredict flush request

Behaviour:
- States: IDLE, BUSY, FLUSH. Reset puts state in IDLE and the round-robin pointer at 0. All outputs are 0 during and immediately after reset.
- IDLE:
  - If bu_ops_ready_i=1, flush_i=0 and any req_valid_i=1, pick the first valid requester at or after the pointer, wrapping modulo N_REQ.
  - Assert req_ready_o[g], bu_sel_o[g] and bu_ops_valid_o combinationally in that cycle.
  - Capture g and req_tag_i[g] into the in-flight registers. Set pointer = (g+1) mod N_REQ. Go to BUSY.
  - Otherwise stay in IDLE and keep the pointer unchanged.
- bu_ops_valid_o depends only on req_valid_i and state, never on bu_ops_ready_i. A grant is issued only when ready=1.
- BUSY: no grants. When bu_res_valid_i=1:
  - Next cycle, res_valid_o=1 with res_src_o, res_tag_o, res_taken_o and res_mispredict_o registered.
  - If bu_res_mispredict_i=1, go to FLUSH. Otherwise go to IDLE.
- FLUSH: flush_o=1 for exactly one cycle, no grants, then go to IDLE.
- Result latency: res_valid_o rises 1 cycle after bu_res_valid_i. With the branch unit's single-cycle evaluation, an op granted at cycle t produces res_valid_o at t+2.
- flush_i in BUSY:
  - The in-flight op is killed and the state goes to IDLE.
  - A bu_res_valid_i in the same cycle is dropped: no res_valid_o and no flush_o.
- flush_i in IDLE suppresses the grant in that cycle.
- flush_i in FLUSH has no additional effect.
- A bu_res_valid_i arriving in IDLE or FLUSH is a protocol error. It is ignored and produces no output.
- The pointer advances only on a grant. It is unaffected by flush or timeout.
- Back-to-back throughput: at most one grant every 2 cycles, or 3 cycles after a mispredict.

Optional Feature:
- Macro: BRANCH_ARB_TIMEOUT_EN.
- When defined:
  - Adds output timeout_o (1 bit) and a $clog2(TIMEOUT+1)-bit counter, cleared on entry to BUSY and incremented each BUSY cycle.
  - If the counter reaches TIMEOUT without bu_res_valid_i, pulse timeout_o for 1 cycle and return to IDLE with no res_valid_o.
  - A result arriving in the same cycle as the timeout wins: normal result, no timeout.
- When not defined: neither the port nor the counter exists, and BUSY waits indefinitely.

Decomposition:
- mmm_pkg gains the typedef brarb_state_t (IDLE, BUSY, FLUSH) and a constant for the default TIMEOUT.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational; reusable by other issue arbiters.

Test Plan:
- Reset, then req_valid_i=4'b1111 held with bu_ops_ready_i=1 and no mispredicts:
  - Grants go to 0,1,2,3,0 at cycles 0,2,4,6,8.
  - res_src_o follows the same order with tags matching req_tag_i.
- Only req 2 valid with tag 5'd17, result taken=1, mispredict=1:
  - res_valid_o with src=2, tag=17, taken=1, mispredict=1.
  - flush_o=1 exactly in the next cycle.
  - The next grant comes no earlier than 3 cycles after the first.
- flush_i asserted in the same cycle as bu_res_valid_i:
  - No res_valid_o and no flush_o; state returns to IDLE.
  - A pending request is granted next cycle.
- bu_ops_ready_i=0 for 5 cycles with req 1 valid:
  - req_ready_o stays 0 and bu_ops_valid_o stays 1.
  - Grant occurs in the first cycle ready=1; the pointer is unchanged during the wait.
- Reset asserted mid-BUSY:
  - All outputs 0 and pointer 0.
  - A result pulse during reset produces no output.
- With BRANCH_ARB_TIMEOUT_EN and TIMEOUT=15, grant with no result:
  - timeout_o pulses exactly 15 cycles after entry to BUSY.
  - The next grant is accepted afterwards.
